byte_input_handler: RTL
=======================

# byte_input_handler

Upstream stage of the host-to-wishbone path. It takes a raw byte stream from the host link (UART/FIFO receiver), finds packet framing, and assembles big-endian 32-bit command, address and data words. It presents each completed packet to the wishbone master with a one-cycle strobe, and only when the master reports ready. It also provides an inter-byte timeout so a truncated packet cannot wedge the link.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hCD, framing byte that starts every packet.
- `TIMEOUT_CYCLES`, 1_000_000, maximum idle clocks allowed between bytes inside a packet.
- `TO_WIDTH`, 20, timeout counter width; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `byte_valid`  in  1  `byte_data` holds a byte.
- `byte_data`  in  8  received byte.
- `byte_ready`  out  1  handler accepts a byte this cycle; a transfer occurs when `byte_valid && byte_ready`.
- `master_ready`  in  1  downstream master can take a packet.
- `ih_ready`  out  1  one-cycle strobe: the `ih_*` words are valid.
- `ih_command`  out  32  packet command word.
- `ih_address`  out  32  packet address word.
- `ih_data`  out  32  packet data word.
- `sync_err`  out  1  one-cycle pulse: a non-sync byte was discarded while hunting.
- `timeout_err`  out  1  one-cycle pulse: a partial packet was dropped on timeout.

## Operation
- Packet format: `SYNC_BYTE`, then command[31:24..7:0], then address (4 bytes, MSB first), then data (4 bytes, MSB first). Total 13 bytes.
- States:
  - `IDLE`: hunting for sync.
  - `CMD`, `ADDR`, `DATA`: each collects 4 bytes using a 2-bit byte index.
  - `SEND`: packet complete, waiting for the master.
- `IDLE`:
  - Accepted byte equal to `SYNC_BYTE` → `CMD`, index=0.
  - Any other accepted byte → discard, pulse `sync_err` the next cycle, stay in `IDLE`.
- `CMD`, `ADDR`, `DATA`:
  - Each accepted byte shifts into the current word: word <= {word[23:0], byte}.
  - Index increments by 1 and wraps 3→0. On the wrap, go to the next state (`CMD`→`ADDR`→`DATA`→`SEND`).
- `SEND`:
  - `byte_ready`=0.
  - When `master_ready`=1, assert `ih_ready` for exactly one cycle and return to `IDLE`.
  - The `ih_*` words hold their value until the next packet overwrites them.
- Timeout:
  - The counter runs only in `CMD`, `ADDR` and `DATA`, and clears on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES`: go to `IDLE`, pulse `timeout_err`, and leave `ih_*` unchanged (the partial word is not presented).
- Sync bytes are not special inside a packet; 0xCD is legal payload.

## Timing
- Reset values: `byte_ready`=0, `ih_ready`=0, `ih_command`=`ih_address`=`ih_data`=0, `sync_err`=0, `timeout_err`=0, state=`IDLE`, counters=0.
- `byte_ready` is a registered output. It is 1 in every state except `SEND`, starting the first cycle after reset deasserts.
- Back-to-back bytes (one per cycle) are accepted without stalls.
- Latency and master handshake:
  - The last data byte is accepted in cycle N; state=`SEND` in N+1.
  - If `master_ready` is high in N+1, `ih_ready`=1 in N+2.
  - The earliest next byte accept is N+2, since `byte_ready` is high again in N+2.
- A byte accepted in the same cycle the counter reaches `TIMEOUT_CYCLES`: the byte wins, the counter clears, and there is no error.
- `rst` asserted mid-packet: immediate return to reset values, with no `ih_ready` or error pulse. The partial packet is lost.
- `master_ready` dropping while in `SEND` only delays the strobe. Data is never lost, and upstream bytes are held off by `byte_ready`=0.

## Structure
- Shared package (`host_if_pkg`), used by this block and the wishbone master:
  - packet constants: `SYNC_BYTE` default, bytes per word (4), words per packet (3);
  - state encoding for `IDLE`, `CMD`, `ADDR`, `DATA`, `SEND`;
  - command code constants (PING=0 … INTERRUPT=8).
- One sub-module: `ih_timeout_timer`.
  - Parameterised counter with inputs `clear` and `enable`, and output `expired`.
  - Asynchronous reset, identical to the parent.
- Shifting and the FSM stay in the top module.

## Test plan
- Ping: bytes CD,00×12 with `master_ready`=1 → one `ih_ready` pulse, 2 cycles after the last byte; all `ih_*`=0.
- Write: CD,00,00,00,01,00,00,01,00,DE,AD,BE,EF → `ih_command`=1, `ih_address`=32'h100, `ih_data`=32'hDEADBEEF.
- Master hold-off: same packet with `master_ready`=0 for 20 cycles → `byte_ready`=0 throughout; `ih_ready` fires 1 cycle after `master_ready` rises; next packet decodes correctly.
- Garbage hunt: bytes 11,22,33 then a valid packet → three `sync_err` pulses, then a correct packet.
- Timeout (`TIMEOUT_CYCLES`=16):
  - CD,00,00 then 16 idle cycles → `timeout_err` pulse, no `ih_ready`, state `IDLE`;
  - a following full packet decodes correctly.
  - Also: a byte arriving exactly at count 16 → no error.
- Reset mid-packet: `rst` after 6 bytes → all outputs at reset values immediately; a following full packet decodes correctly.

Source files
------------

// File: rtl/host_if_pkg.sv
// host_if_pkg: packet framing constants, FSM encoding and command codes shared by the host-to-wishbone path
package host_if_pkg;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hCD;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORDS_PER_PKT = 3;
  localparam int PKT_W = 8 * BYTES_PER_WORD * WORDS_PER_PKT;
  localparam logic [31:0] CMD_PING = 32'd0;
  localparam logic [31:0] CMD_WRITE = 32'd1;
  localparam logic [31:0] CMD_READ = 32'd2;
  localparam logic [31:0] CMD_WRITE_BURST = 32'd3;
  localparam logic [31:0] CMD_READ_BURST = 32'd4;
  localparam logic [31:0] CMD_RESET = 32'd5;
  localparam logic [31:0] CMD_STATUS = 32'd6;
  localparam logic [31:0] CMD_CONFIG = 32'd7;
  localparam logic [31:0] CMD_INTERRUPT = 32'd8;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_SEND} state_t;
  function automatic state_t next_word_state(state_t s);
    return s == ST_CMD ? ST_ADDR : s == ST_ADDR ? ST_DATA : ST_SEND;
  endfunction
endpackage

// File: rtl/byte_input_handler_if.sv
// byte_input_handler_if: byte stream in, assembled packet out
interface byte_input_handler_if;
  logic byte_valid;
  logic [7:0] byte_data;
  logic byte_ready;
  logic master_ready;
  logic ih_ready;
  logic [31:0] ih_command;
  logic [31:0] ih_address;
  logic [31:0] ih_data;
  logic sync_err;
  logic timeout_err;
  modport slave (
    input byte_valid, byte_data, master_ready,
    output byte_ready, ih_ready, ih_command, ih_address, ih_data, sync_err, timeout_err
  );
  modport master (
    output byte_valid, byte_data, master_ready,
    input byte_ready, ih_ready, ih_command, ih_address, ih_data, sync_err, timeout_err
  );
endinterface

// File: rtl/ih_timeout_timer.sv
// ih_timeout_timer: idle-cycle counter that flags when TIMEOUT_CYCLES is reached while enabled
module ih_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_WIDTH = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = enable && cnt_q == TO_WIDTH'(TIMEOUT_CYCLES);
endmodule

// File: rtl/byte_input_handler.sv
// byte_input_handler: frames host bytes into command/address/data words and hands them to the wishbone master
module byte_input_handler
  import host_if_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_WIDTH = 20
) (
  input logic clk,
  input logic rst,
  byte_input_handler_if.slave bus
);
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [31:0] cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
  logic byte_ready_q, byte_ready_d, ih_ready_q, ih_ready_d;
  logic sync_err_q, sync_err_d, timeout_err_q, timeout_err_d;
  logic acc, in_pkt, expired;
  assign acc = bus.byte_valid && byte_ready_q;
  assign in_pkt = state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA;
  ih_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_WIDTH(TO_WIDTH)) u_timer (
    .clk(clk), .rst(rst), .clear(acc || !in_pkt), .enable(in_pkt), .expired(expired)
  );
  // an accepted byte takes priority over a timeout that expires in the same cycle
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    pkt_d = pkt_q;
    cmd_d = cmd_q;
    addr_d = addr_q;
    data_d = data_q;
    ih_ready_d = 1'b0;
    sync_err_d = 1'b0;
    timeout_err_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (acc) begin
        sync_err_d = bus.byte_data != SYNC_BYTE;
        state_d = bus.byte_data == SYNC_BYTE ? ST_CMD : ST_IDLE;
        idx_d = 2'd0;
      end
    end else if (state_q == ST_SEND) begin
      if (bus.master_ready) begin
        ih_ready_d = 1'b1;
        cmd_d = pkt_q[95:64];
        addr_d = pkt_q[63:32];
        data_d = pkt_q[31:0];
        state_d = ST_IDLE;
      end
    end else if (acc) begin
      pkt_d = {pkt_q[PKT_W-9:0], bus.byte_data};
      idx_d = idx_q + 2'd1;
      state_d = idx_q == 2'd3 ? next_word_state(state_q) : state_q;
    end else if (expired) begin
      state_d = ST_IDLE;
      timeout_err_d = 1'b1;
    end
    byte_ready_d = state_d != ST_SEND;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      pkt_q <= '0;
      cmd_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      byte_ready_q <= 1'b0;
      ih_ready_q <= 1'b0;
      sync_err_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pkt_q <= pkt_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      data_q <= data_d;
      byte_ready_q <= byte_ready_d;
      ih_ready_q <= ih_ready_d;
      sync_err_q <= sync_err_d;
      timeout_err_q <= timeout_err_d;
    end
  assign bus.byte_ready = byte_ready_q;
  assign bus.ih_ready = ih_ready_q;
  assign bus.ih_command = cmd_q;
  assign bus.ih_address = addr_q;
  assign bus.ih_data = data_q;
  assign bus.sync_err = sync_err_q;
  assign bus.timeout_err = timeout_err_q;
endmodule
